// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO.
// Bytes are queued through a valid/ready push port and shifted out LSB first,
// each bit held for max(cfg_divider, 2) clocks.
module uart_tx_fifo #(
    parameter int FIFO_AW = 2,
    parameter int DIV_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] cfg_divider,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_tx,
    output logic             busy,
    output logic [FIFO_AW:0] fifo_level,
    output logic [1:0]       o_dbg_state
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DIV_MIN = {{(DIV_W-2){1'b0}}, 2'b10};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FIFO storage and pointers; one extra pointer bit separates full from empty.
    logic [7:0]       r_mem [DEPTH];
    logic [FIFO_AW:0] r_wptr;
    logic [FIFO_AW:0] r_rptr;

    // Transmit engine state.
    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_div_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_ser_tx;
    logic             r_busy;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_bit_end;
    logic             w_frame_continues;
    logic             w_busy_nxt;
    logic [DIV_W-1:0] w_div_eff;
    logic [7:0]       w_head;
    logic [FIFO_AW:0] w_wptr_nxt;
    logic [FIFO_AW:0] w_rptr_nxt;

    // Push handshake: a byte transfers on every rising edge where in_valid and
    // in_ready are both high. in_ready depends only on the registered pointers,
    // so it never combinationally follows in_valid, and a pop in the cycle the
    // FIFO is full only raises in_ready on the following cycle.
    assign w_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                     (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_push  = in_valid && !w_full;

    // The end of a bit period is when the down-counter has reached zero.
    assign w_bit_end = (r_div_cnt == '0);

    // A new frame starts from IDLE, or straight out of the stop bit so that
    // queued bytes go out back to back with no idle gap.
    assign w_pop = !w_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

    // Divider values below 2 are clamped to 2.
    assign w_div_eff = (cfg_divider < DIV_MIN) ? DIV_MIN : cfg_divider;

    assign w_head     = r_mem[r_rptr[FIFO_AW-1:0]];
    assign w_wptr_nxt = r_wptr + {{FIFO_AW{1'b0}}, w_push};
    assign w_rptr_nxt = r_rptr + {{FIFO_AW{1'b0}}, w_pop};

    // A frame stays in progress unless we are idle or the stop bit is ending.
    assign w_frame_continues = (r_state != S_IDLE) &&
                               !((r_state == S_STOP) && w_bit_end);
    assign w_busy_nxt = w_pop || w_frame_continues || (w_wptr_nxt != w_rptr_nxt);

    // FIFO pointer update; reset discards everything queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            r_wptr <= w_wptr_nxt;
            r_rptr <= w_rptr_nxt;
        end
    end

    // FIFO storage write; a push during reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wptr[FIFO_AW-1:0]] <= in_data;
        end
    end

    // Frame sequencer: start bit, eight data bits LSB first, stop bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ser_tx  <= 1'b1;
            r_busy    <= 1'b0;
            r_div     <= '0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            case (r_state)
                S_IDLE: begin
                    r_ser_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift   <= w_head;
                        r_div     <= w_div_eff;
                        r_div_cnt <= w_div_eff - DIV_ONE;
                        r_ser_tx  <= 1'b0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_ser_tx  <= r_shift[0];
                        r_div_cnt <= r_div - DIV_ONE;
                        r_bit_cnt <= 3'd0;
                        r_state   <= S_DATA;
                    end else begin
                        r_div_cnt <= r_div_cnt - DIV_ONE;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_div_cnt <= r_div - DIV_ONE;
                        if (r_bit_cnt == 3'd7) begin
                            r_ser_tx <= 1'b1;
                            r_state  <= S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_ser_tx  <= r_shift[1];
                            r_shift   <= r_shift >> 1;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt - DIV_ONE;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_shift   <= w_head;
                            r_div     <= w_div_eff;
                            r_div_cnt <= w_div_eff - DIV_ONE;
                            r_ser_tx  <= 1'b0;
                            r_state   <= S_START;
                        end else begin
                            r_ser_tx <= 1'b1;
                            r_state  <= S_IDLE;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt - DIV_ONE;
                    end
                end
                default: begin
                    r_ser_tx <= 1'b1;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = !w_full;
    assign ser_tx      = r_ser_tx;
    assign busy        = r_busy;
    assign fifo_level  = r_wptr - r_rptr;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a frame-timing reference model, a mid-bit serial
// receiver and a byte scoreboard, driven by directed steps plus random traffic.
module tb_uart_tx_fifo;

    localparam int FIFO_AW = 2;
    localparam int DIV_W   = 16;
    localparam int DEPTH   = 1 << FIFO_AW;

    logic             clk = 1'b0;
    logic             reset;
    logic [DIV_W-1:0] cfg_divider;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_tx;
    logic             busy;
    logic [FIFO_AW:0] fifo_level;
    logic [1:0]       dbg_state;

    uart_tx_fifo #(.FIFO_AW(FIFO_AW), .DIV_W(DIV_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_divider (cfg_divider),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ser_tx      (ser_tx),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .o_dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes waiting (excluding the one on the line) and the
    // frame currently on the line, described by its byte, divider and age.
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    bit         m_act = 1'b0;
    int         m_t   = 0;
    int         m_div = 2;
    logic [7:0] m_cur = 8'h00;
    bit         m_acc = 1'b0;

    // Serial receiver state.
    bit         rx_active = 1'b0;
    int         rx_cnt    = 0;
    int         rx_div    = 2;
    logic [7:0] rx_byte   = 8'h00;
    logic       rx_prev   = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Line level of bit slot k of a frame: start, data LSB first, stop.
    function automatic logic line_level(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    // One clock: advance the model, compare all outputs, feed the receiver.
    task automatic tick();
        bit         rst;
        bit         acc;
        int         cfg;
        int         k;
        logic [7:0] d;
        rst = reset;
        cfg = int'(cfg_divider);
        d   = in_data;
        acc = in_valid && (m_q.size() < DEPTH) && !reset;
        @(posedge clk);
        #1;
        m_acc = acc;
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            m_act     = 1'b0;
            m_t       = 0;
            rx_active = 1'b0;
        end else begin
            if (m_act) begin
                m_t++;
                if (m_t >= 10 * m_div) m_act = 1'b0;
            end
            if (!m_act && m_q.size() != 0) begin
                m_cur = m_q.pop_front();
                m_div = (cfg < 2) ? 2 : cfg;
                m_t   = 0;
                m_act = 1'b1;
            end
            if (acc) begin
                m_q.push_back(d);
                exp_q.push_back(d);
            end
        end

        check("ser_tx", 32'(ser_tx), 32'(m_act ? line_level(m_cur, m_t / m_div) : 1'b1));
        check("busy", 32'(busy), 32'(m_act || (m_q.size() != 0)));
        check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        check("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));

        if (!rx_active) begin
            if (rx_prev === 1'b1 && ser_tx === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
                rx_div    = m_act ? m_div : 2;
                rx_byte   = 8'h00;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % rx_div == rx_div / 2) begin
                k = rx_cnt / rx_div;
                if (k >= 1 && k <= 8) begin
                    rx_byte[k-1] = ser_tx;
                end else if (k >= 9) begin
                    check("rx_stop_bit", 32'(ser_tx), 32'(1));
                    check("rx_byte_pending", 32'(exp_q.size() != 0), 32'(1));
                    if (exp_q.size() != 0) check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
                    rx_active = 1'b0;
                end
            end
        end
        rx_prev = ser_tx;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Hold a byte on the push port until the FIFO takes it.
    task automatic push(input logic [7:0] b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = b;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 2000);
        check("push_accepted", 32'(m_acc), 32'(1));
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        cfg_divider = 16'd6;
        tick();
        tick();
        reset = 1'b0;
        check("reset_ser_tx", 32'(ser_tx), 32'(1));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_level", 32'(fifo_level), 32'(0));
        check("reset_ready", 32'(in_ready), 32'(1));
        tick();

        // Single byte at divider 6; start bit appears the edge after acceptance.
        push(8'h55);
        check("t1_still_idle_line", 32'(ser_tx), 32'(1));
        tick();
        check("t1_start_bit", 32'(ser_tx), 32'(0));
        run(70);

        // Back-to-back bytes filling the FIFO, then a push held off while full.
        push(8'hA3);
        push(8'h0D);
        push(8'h0A);
        push(8'h41);
        push(8'h42);
        check("t2_level_full", 32'(fifo_level), 32'(4));
        check("t2_ready_low", 32'(in_ready), 32'(0));
        push(8'h5A);
        run(380);

        // Divider clamp, then a mid-frame divider change applying to the next frame.
        cfg_divider = 16'd0;
        push(8'hFF);
        run(5);
        cfg_divider = 16'd10;
        push(8'h3C);
        run(140);

        // Reset during data bit 3 with a second byte queued and a push in the reset cycle.
        cfg_divider = 16'd6;
        push(8'h00);
        push(8'h11);
        n = 0;
        while (!(m_act && (m_t / m_div) == 4) && n < 200) begin
            tick();
            n++;
        end
        check("t4_reached_bit3", 32'(n < 200), 32'(1));
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        check("t4_ser_tx", 32'(ser_tx), 32'(1));
        check("t4_busy", 32'(busy), 32'(0));
        check("t4_level", 32'(fifo_level), 32'(0));
        check("t4_ready", 32'(in_ready), 32'(1));
        run(80);
        push(8'h7E);
        run(70);

        // Push on the exact cycle a stop bit ends while one byte is queued.
        cfg_divider = 16'd4;
        push(8'hC1);
        push(8'hC2);
        n = 0;
        while (!(m_act && m_cur == 8'hC1 && m_t == 10 * m_div - 1) && n < 200) begin
            tick();
            n++;
        end
        check("t5_reached_stop_end", 32'(n < 200), 32'(1));
        in_valid = 1'b1;
        in_data  = 8'hC3;
        tick();
        in_valid = 1'b0;
        check("t5_level_kept", 32'(fifo_level), 32'(1));
        run(100);

        // Random traffic with occasional divider changes.
        repeat (800) begin
            in_valid = ($urandom_range(0, 2) == 0);
            in_data  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) == 0) cfg_divider = 16'($urandom_range(0, 5));
            tick();
        end
        in_valid = 1'b0;

        // Drain everything still queued or on the line.
        n = 0;
        while ((m_act || m_q.size() != 0 || rx_active) && n < 3000) begin
            tick();
            n++;
        end
        check("drain_done", 32'(n < 3000), 32'(1));
        run(5);
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Synthesizable 8N1 UART transmitter with a small byte FIFO and a programmable baud divider. It is the transmit end of the serial link whose receive end is the bench's serial monitor. The PicoSoC top uses it to drive console output on `ser_tx`, and benches use it to inject bytes into the SoC's `ser_rx`. Bytes are pushed through a valid/ready handshake and serialized LSB-first at `cfg_divider` clocks per bit.

Parameters:
- `FIFO_AW`, default 2: log2 of the FIFO depth. Depth = 2^FIFO_AW entries, so 4 by default.
- `DIV_W`, default 16: width of the divider input.

Ports:
- `clk`  in  1: system clock. All logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `cfg_divider`  in  DIV_W: clocks per bit. Values 0 and 1 are treated as 2.
- `in_data`  in  8: byte to transmit.
- `in_valid`  in  1: `in_data` is valid this cycle.
- `in_ready`  out  1: the FIFO can accept a byte (not full).
- `ser_tx`  out  1: serial line, idle high. Registered output.
- `busy`  out  1: a frame is in progress or the FIFO is non-empty.
- `fifo_level`  out  FIFO_AW+1: number of bytes queued, excluding the byte currently being shifted.

Behaviour:
- Reset values:
  - `ser_tx`=1, `busy`=0, `in_ready`=1, `fifo_level`=0.
  - FIFO pointers cleared, FSM in IDLE, bit and divider counters at 0.
- Push handshake:
  - A byte is accepted on any rising edge where `in_valid` && `in_ready`.
  - `in_ready` = !full, computed from registered pointers only. It has no combinational path from `in_valid`.
- FIFO:
  - Circular buffer with FIFO_AW+1-bit read and write pointers. Wrap-around is by natural overflow.
  - Full when the pointers differ only in the MSB. Empty when they are equal.
  - Simultaneous push and pop in one cycle leaves `fifo_level` unchanged.
  - When full, a pop in the same cycle does not make `in_ready` high until the next cycle.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `ser_tx`=1. When the FIFO is non-empty, pop the head byte into the shift register, latch the effective divider (max(`cfg_divider`,2)), drive `ser_tx`=0, and go to START.
  - Latency: a byte accepted at edge E into an empty, idle block shows `ser_tx`=0 from edge E+1.
  - START: hold for exactly div cycles, then output data bit 0 and go to DATA.
  - DATA: each bit is held div cycles. Bits go out LSB first, 8 bits, with the bit counter running 0..7. After bit 7's period, drive `ser_tx`=1 and go to STOP.
  - STOP: hold `ser_tx`=1 for div cycles.
    - At the end of STOP, if the FIFO is non-empty, pop and go directly to START with no extra idle cycle. This gives back-to-back frames of exactly 10*div cycles each.
    - Otherwise go to IDLE.
- Divider:
  - Down-counter reloaded with div-1 at each bit boundary.
  - `cfg_divider` is sampled only at frame start. Changes mid-frame take effect on the next frame.
- `busy`: registered. It is 1 in any state other than IDLE, or when the FIFO is non-empty.
- Reset mid-frame:
  - Takes effect on the next edge. `ser_tx` returns to 1 immediately, with no partial stop bit.
  - FIFO contents are discarded.
  - A push asserted in the reset cycle is dropped.
- No parity, and no break generation.

Test Plan:
1. Single byte, divider: `cfg_divider`=6, push 0x55 → `ser_tx` low from the edge after acceptance.
   - Line pattern 0,1,0,1,0,1,0,1,0,1, each level exactly 6 cycles, then idle high.
   - A bench receiver sampling mid-bit (3 cycles in, then every 6) decodes 0x55. `busy` deasserts 60 cycles after the start bit begins.
2. Back-to-back and full: push 0xA3, 0x0D, 0x0A, 0x41, 0x42 on consecutive cycles (div=6).
   - The first byte enters the shifter. The next 4 fill the FIFO: `fifo_level`=4 and `in_ready`=0.
   - The 6th push is held off until the next pop.
   - Five frames come out back-to-back with no gap: 300 cycles total, decoded in order.
3. Divider clamp and sampling: `cfg_divider`=0, push 0xFF.
   - Every bit lasts 2 cycles.
   - Changing `cfg_divider` to 10 mid-frame leaves the current frame at 2 cycles per bit. The next frame uses 10.
4. Reset mid-frame: div=6, push 0x00 and 0x11, assert `reset` during data bit 3.
   - Next edge: `ser_tx`=1, `busy`=0, `fifo_level`=0, `in_ready`=1.
   - No further line activity.
   - A subsequent push of 0x7E transmits correctly.
5. Simultaneous push and pop: FIFO holding 1 byte, push exactly on the cycle STOP ends.
   - `fifo_level` stays 1.
   - Byte order is preserved across the pointer wrap after ≥2^FIFO_AW+1 total pushes.
